// File: rtl/stream_demux_rr.sv
// stream_demux_rr: one valid/ready input stream fanned out to N_OUT valid/ready
// outputs. Each output owns a one-entry registered slot. The destination is
// either the per-beat in_dest field or a strict round-robin pointer. Beats
// aimed past the last channel are accepted and discarded with a drop pulse.

// One output slot: load wins over drain, so drain+refill keeps the slot full.
module stream_demux_rr_slot #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             ready_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;

   // next slot state: refill takes priority; data is kept after drain
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   // slot register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
endmodule

module stream_demux_rr #(
   parameter  int WIDTH  = 8,
   parameter  int N_OUT  = 4,
   localparam int DEST_W = $clog2(N_OUT)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rr_en,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   input  logic [DEST_W-1:0]      in_dest,
   output logic [N_OUT-1:0]       out_valid,
   input  logic [N_OUT-1:0]       out_ready,
   output logic [N_OUT*WIDTH-1:0] out_data,
   output logic                   drop,
   output logic [DEST_W-1:0]      rr_ptr
);
   // one extra bit so N_OUT itself fits when N_OUT is a power of two
   localparam logic [DEST_W:0] N_OUT_EXT = (DEST_W+1)'(N_OUT);

   logic [DEST_W-1:0] dest;
   logic              dest_oor;
   logic              accept;
   logic [N_OUT-1:0]  load;
   logic [DEST_W-1:0] rr_ptr_q, rr_ptr_d;
   logic              drop_q, drop_d;

   assign dest     = rr_en ? rr_ptr_q : in_dest;
   assign dest_oor = !rr_en && ({1'b0, in_dest} >= N_OUT_EXT);
   assign accept   = in_valid && in_ready;

   // ready from the addressed slot only (no skipping to a free channel);
   // out-of-range beats are always taken so they never block the stream
   always_comb begin
      in_ready = dest_oor;
      load     = '0;
      for (int k = 0; k < N_OUT; k++) begin
         if (!dest_oor && dest == DEST_W'(k)) begin
            in_ready = !out_valid[k] || out_ready[k];
            load[k]  = in_valid && (!out_valid[k] || out_ready[k]);
         end
      end
   end

   // pointer advances only on an accepted round-robin beat; drop flags a discard
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept && rr_en)
         rr_ptr_d = (rr_ptr_q == DEST_W'(N_OUT-1)) ? '0 : rr_ptr_q + DEST_W'(1);
      drop_d = accept && dest_oor;
   end

   // pointer and drop pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
         drop_q   <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         drop_q   <= drop_d;
      end
   end

   for (genvar k = 0; k < N_OUT; k++) begin : g_slot
      stream_demux_rr_slot #(.WIDTH(WIDTH)) u_slot (
         .clk     (clk),
         .rst_n   (rst_n),
         .load_i  (load[k]),
         .ready_i (out_ready[k]),
         .data_i  (in_data),
         .valid_o (out_valid[k]),
         .data_o  (out_data[k*WIDTH +: WIDTH])
      );
   end

   assign drop   = drop_q;
   assign rr_ptr = rr_ptr_q;
endmodule

// File: tb/tb_stream_demux_rr.sv
// Bench for stream_demux_rr: directed vector table, hand-written reset and
// out-of-range sequences, then a randomized soak against a queue scoreboard.
module tb_stream_demux_rr;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // main DUT, N_OUT=4
   logic        rr_en, in_valid, in_ready, drop;
   logic [7:0]  in_data;
   logic [1:0]  in_dest, rr_ptr;
   logic [3:0]  out_valid, out_ready;
   logic [31:0] out_data;

   stream_demux_rr #(.WIDTH(8), .N_OUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .rr_en(rr_en), .in_valid(in_valid),
      .in_ready(in_ready), .in_data(in_data), .in_dest(in_dest),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .drop(drop), .rr_ptr(rr_ptr));

   // second DUT, N_OUT=3, for the out-of-range destination
   logic        rr3, v3, rdy3, drop3;
   logic [7:0]  dat3;
   logic [1:0]  d3, ptr3;
   logic [2:0]  vld3, ordy3;
   logic [23:0] odat3;

   stream_demux_rr #(.WIDTH(8), .N_OUT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .rr_en(rr3), .in_valid(v3),
      .in_ready(rdy3), .in_data(dat3), .in_dest(d3),
      .out_valid(vld3), .out_ready(ordy3), .out_data(odat3),
      .drop(drop3), .rr_ptr(ptr3));

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic       rr;
      logic       v;
      logic [1:0] dst;
      logic [7:0] dat;
      logic [3:0] ordy;
      logic       erdy;
      logic [3:0] evld;
      logic [1:0] eptr;
      int         ch;
      logic [7:0] edat;
   } vec_t;

   vec_t tbl[17];

   // scoreboard: per-channel queue of accepted-but-not-delivered beats
   logic [7:0] sq[4][$];
   int         m_ptr;

   // one soak cycle: check pre-edge view against the scoreboard, then advance it
   task automatic soak_step(output logic acc);
      int          d;
      logic [3:0]  ev;
      logic        erdy;
      logic [3:0]  ordy_s;
      @(negedge clk);
      d    = rr_en ? m_ptr : int'(in_dest);
      erdy = (sq[d].size() == 0) || out_ready[d];
      chk("soak_in_ready", in_ready, erdy);
      for (int k = 0; k < 4; k++) begin
         ev[k] = sq[k].size() != 0;
         if (ev[k]) chk($sformatf("soak_data%0d", k), out_data[k*8 +: 8], sq[k][0]);
      end
      chk("soak_out_valid", out_valid, ev);
      chk("soak_rr_ptr", rr_ptr, m_ptr[1:0]);
      chk("soak_drop", drop, 1'b0);
      acc    = in_valid && erdy;
      ordy_s = out_ready;
      @(posedge clk);
      for (int k = 0; k < 4; k++)
         if (ordy_s[k] && sq[k].size() != 0) void'(sq[k].pop_front());
      if (acc) begin
         sq[d].push_back(in_data);
         if (rr_en) m_ptr = (m_ptr + 1) % 4;
      end
      #1;
   endtask

   initial begin
      logic acc;
      int   nacc, ncyc;

      rst_n = 1'b0; rr_en = 0; in_valid = 0; in_data = 0; in_dest = 0; out_ready = 0;
      rr3 = 0; v3 = 0; dat3 = 0; d3 = 0; ordy3 = 0;

      // directed destination, stall, drain+refill, round-robin wrap, rotation stall
      tbl[0]  = '{1'b0, 1'b1, 2'd2, 8'hA5, 4'b0000, 1'b1, 4'b0100, 2'd0, 2, 8'hA5};
      tbl[1]  = '{1'b0, 1'b1, 2'd0, 8'h3C, 4'b0000, 1'b1, 4'b0101, 2'd0, 0, 8'h3C};
      tbl[2]  = '{1'b0, 1'b1, 2'd2, 8'h77, 4'b0000, 1'b0, 4'b0101, 2'd0, 2, 8'hA5};
      tbl[3]  = '{1'b0, 1'b1, 2'd2, 8'h77, 4'b0100, 1'b1, 4'b0101, 2'd0, 2, 8'h77};
      tbl[4]  = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 2'd0, 2, 8'h77};
      tbl[5]  = '{1'b1, 1'b1, 2'd0, 8'h10, 4'b1111, 1'b1, 4'b0001, 2'd1, 0, 8'h10};
      tbl[6]  = '{1'b1, 1'b1, 2'd0, 8'h11, 4'b1111, 1'b1, 4'b0010, 2'd2, 1, 8'h11};
      tbl[7]  = '{1'b1, 1'b1, 2'd0, 8'h12, 4'b1111, 1'b1, 4'b0100, 2'd3, 2, 8'h12};
      tbl[8]  = '{1'b1, 1'b1, 2'd0, 8'h13, 4'b1111, 1'b1, 4'b1000, 2'd0, 3, 8'h13};
      tbl[9]  = '{1'b1, 1'b1, 2'd0, 8'h14, 4'b1111, 1'b1, 4'b0001, 2'd1, 0, 8'h14};
      tbl[10] = '{1'b0, 1'b1, 2'd1, 8'h20, 4'b0000, 1'b1, 4'b0011, 2'd1, 1, 8'h20};
      tbl[11] = '{1'b1, 1'b1, 2'd0, 8'h21, 4'b0000, 1'b0, 4'b0011, 2'd1, 1, 8'h20};
      tbl[12] = '{1'b1, 1'b1, 2'd0, 8'h21, 4'b0000, 1'b0, 4'b0011, 2'd1, 1, 8'h20};
      tbl[13] = '{1'b1, 1'b1, 2'd0, 8'h21, 4'b0010, 1'b1, 4'b0011, 2'd2, 1, 8'h21};
      tbl[14] = '{1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 2'd2, 1, 8'h21};
      tbl[15] = '{1'b0, 1'b1, 2'd3, 8'h30, 4'b0000, 1'b1, 4'b1000, 2'd2, 3, 8'h30};
      tbl[16] = '{1'b1, 1'b1, 2'd0, 8'h31, 4'b0000, 1'b1, 4'b1100, 2'd3, 2, 8'h31};

      // reset state, observed while reset is held
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 4'b0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_rr_ptr", rr_ptr, 2'd0);
      chk("rst_drop", drop, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 17; i++) begin
         rr_en = tbl[i].rr; in_valid = tbl[i].v; in_dest = tbl[i].dst;
         in_data = tbl[i].dat; out_ready = tbl[i].ordy;
         @(negedge clk);
         chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].erdy);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].evld);
         chk($sformatf("v%0d_rr_ptr", i), rr_ptr, tbl[i].eptr);
         chk($sformatf("v%0d_data", i), out_data[tbl[i].ch*8 +: 8], tbl[i].edat);
         chk($sformatf("v%0d_drop", i), drop, 1'b0);
      end

      // asynchronous reset mid-stream with out_valid = 0101
      rr_en = 0; in_valid = 0; out_ready = 4'b1111;
      @(posedge clk); #1;
      out_ready = 4'b0000; in_valid = 1; in_dest = 0; in_data = 8'h3C;
      @(posedge clk); #1;
      in_dest = 2; in_data = 8'hA5;
      @(posedge clk); #1;
      in_valid = 0;
      chk("pre_rst_valid", out_valid, 4'b0101);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 4'b0);
      chk("arst_out_data", out_data, 32'h0);
      chk("arst_rr_ptr", rr_ptr, 2'd0);
      chk("arst_drop", drop, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // out-of-range destination on the 3-channel instance
      v3 = 1; d3 = 2'd1; dat3 = 8'h55;
      @(posedge clk); #1;
      d3 = 2'd3; dat3 = 8'hEE;
      @(negedge clk);
      chk("oor_in_ready", rdy3, 1'b1);
      @(posedge clk); #1;
      v3 = 0;
      chk("oor_drop", drop3, 1'b1);
      chk("oor_out_valid", vld3, 3'b010);
      chk("oor_data1", odat3[15:8], 8'h55);
      @(posedge clk); #1;
      chk("oor_drop_clear", drop3, 1'b0);
      chk("oor_out_valid2", vld3, 3'b010);

      // randomized soak: 1000 accepted beats with rr_en=0, then mixed rr_en
      m_ptr = 0;
      nacc = 0; ncyc = 0;
      while (nacc < 1000 && ncyc < 20000) begin
         rr_en = 0; in_valid = ($urandom_range(0, 9) < 7);
         in_dest = 2'($urandom_range(0, 3)); in_data = 8'($urandom);
         out_ready = 4'($urandom);
         soak_step(acc);
         if (acc) nacc++;
         ncyc++;
      end
      chk("soak_accept_count", nacc, 1000);
      for (int i = 0; i < 300; i++) begin
         rr_en = $urandom_range(0, 1); in_valid = $urandom_range(0, 1);
         in_dest = 2'($urandom_range(0, 3)); in_data = 8'($urandom);
         out_ready = 4'($urandom);
         soak_step(acc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/stream_demux_rr.md
Name: stream_demux_rr

Overview:
- Sequential inverse of the team's 2:1 mux: one valid/ready input stream is distributed to N_OUT valid/ready output streams.
- Each output has a one-entry registered slot.
- Destination comes either from a per-beat destination field or from an internal round-robin pointer.
- Used as the fan-out stage ahead of parallel consumers in the combinational/sequential exercise chain.

Parameters:
- WIDTH, 8, payload width in bits.
- N_OUT, 4, number of output channels; legal range 2..16.
- DEST_W, $clog2(N_OUT), width of the destination field; derived, never overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rr_en  input  1  1 = round-robin destination; 0 = destination from in_dest.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept the input beat this cycle.
- in_data  input  WIDTH  input payload.
- in_dest  input  DEST_W  destination channel; used only when rr_en=0.
- out_valid  output  N_OUT  per-channel slot full.
- out_ready  input  N_OUT  per-channel consumer ready.
- out_data  output  N_OUT*WIDTH  channel k payload at bits [k*WIDTH +: WIDTH].
- drop  output  1  registered one-cycle pulse: an out-of-range beat was accepted and discarded.
- rr_ptr  output  DEST_W  current round-robin pointer (status).

Behaviour:
- Reset (rst_n=0, async assert, sync release) sets out_valid=0, out_data=0, drop=0, rr_ptr=0. A reset mid-transfer discards all slot contents.
- Destination:
  - dest = rr_en ? rr_ptr : in_dest.
  - When rr_en=0 and in_dest >= N_OUT, the destination is out of range.
- Handshake:
  - in_ready = 1 when dest is out of range.
  - Otherwise in_ready = !out_valid[dest] || out_ready[dest].
  - in_ready is combinational from rr_en, in_dest, out_valid and out_ready. It never depends on in_valid.
- Transfer: accept = in_valid && in_ready. On accept with an in-range dest:
  - out_valid[dest] <= 1 and out_data[dest] <= in_data at the same edge.
  - Latency is 1 cycle: the beat is visible on the outputs after the accepting edge.
- Drain: when out_valid[k] && out_ready[k] and channel k is not being refilled this cycle, out_valid[k] <= 0. out_data[k] holds its last value; it is not cleared.
- Simultaneous drain and refill of the same channel: the slot stays valid with the new data. This gives full throughput, one beat per cycle per channel.
- Out-of-range beat on accept: no slot changes, and drop <= 1 for exactly one cycle. drop is 0 in every other cycle.
- Round-robin:
  - On each accept with rr_en=1, rr_ptr <= (rr_ptr == N_OUT-1) ? 0 : rr_ptr+1.
  - The pointer holds when there is no accept or when rr_en=0.
  - The pointer is never reset by toggling rr_en.
- Stall: with rr_en=1 and slot[rr_ptr] full and not draining, in_ready=0. The block does not skip to another free channel; strict rotation is preserved.
- Ordering: beats to the same channel leave in acceptance order.
- Stability: out_valid[k] never drops and out_data[k] never changes while out_valid[k]=1 and out_ready[k]=0.
- in_data and in_dest are sampled only on accept. in_valid withdrawn without acceptance has no effect.

Test Plan:
- Reset: rst_n=0 mid-stream with out_valid=4'b0101 -> out_valid=0, out_data=0, rr_ptr=0, drop=0 immediately (asynchronous).
- Directed destination: rr_en=0, beats (dest 2, 8'hA5), (dest 0, 8'h3C), all out_ready=0 -> out_valid=4'b0101, out_data[2]=A5, out_data[0]=3C. A third beat to dest 2 gets in_ready=0 until out_ready[2]=1.
- Round-robin wrap: rr_en=1, out_ready=4'b1111, five back-to-back beats 10..14 -> channels 0,1,2,3,0 receive them, in_ready stays 1, rr_ptr ends at 1.
- Rotation stall: rr_en=1, rr_ptr=1, out_valid[1]=1, out_ready[1]=0 -> in_ready=0 and rr_ptr holds. Raising out_ready[1] for one cycle accepts the beat in that same cycle and leaves out_valid[1]=1 with the new data.
- Out-of-range: N_OUT=3, rr_en=0, in_dest=3, in_valid=1 -> in_ready=1, drop=1 for one cycle, out_valid unchanged.
- Backpressure soak: random out_ready, rr_en=0, 1000 beats with random in-range dest -> per-channel sequences match a scoreboard, with no loss, no duplication and no out_data change while stalled.
